// File: rtl/dvp_frame_gate.sv
// rtl/dvp_frame_gate.sv - DVP capture gate: VSYNC/HSYNC framing, byte-to-pixel packing, line/frame checks
module dvp_frame_gate #(
  parameter int DVP_DATA_W = 8,
  parameter int PXL_BYTES  = 2,
  parameter int PXL_W      = DVP_DATA_W * PXL_BYTES,
  parameter int LINE_PXL   = 640,
  parameter int FRAME_LINE = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DVP_DATA_W+1:0] pxl_info_i,
  input  logic                  pxl_info_vld_i,
  output logic                  pxl_info_rdy_o,
  input  logic                  cfg_start_i,
  input  logic                  cfg_stop_i,
  input  logic                  cfg_single_i,
  input  logic                  cfg_stall_i,
  input  logic                  err_clr_i,
  output logic [PXL_W-1:0]      pxl_o,
  output logic                  pxl_vld_o,
  input  logic                  pxl_rdy_i,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  frame_done_o,
  output logic                  err_o,
  output logic [2:0]            err_code_o
);

  localparam int LINE_BYTES = LINE_PXL * PXL_BYTES;
  localparam int BCW = $clog2(LINE_BYTES + 1);
  localparam int LCW = $clog2(FRAME_LINE + 1);
  localparam int SCW = (PXL_BYTES > 1) ? $clog2(PXL_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_SOF, ACTIVE, LINE_GAP, DONE} state_t;

  state_t state, state_nxt;

  logic [BCW-1:0]        byte_cnt;
  logic [BCW-1:0]        byte_cnt_inc;
  logic [LCW-1:0]        line_cnt;
  logic [SCW-1:0]        sub_cnt;
  logic [PXL_W-1:0]      pack;
  logic [PXL_W-1:0]      pack_nxt;
  logic                  vs, hs;
  logic [DVP_DATA_W-1:0] data;

  logic byte_beat, line_end, len_err, frame_end, last_byte;
  logic fire, room, take, load, drop;
  logic height_ok;

  assign vs   = pxl_info_i[DVP_DATA_W+1];
  assign hs   = pxl_info_i[DVP_DATA_W];
  assign data = pxl_info_i[DVP_DATA_W-1:0];

  // Shift register: after PXL_BYTES shifts the first byte sits in the MSB.
  assign pack_nxt     = PXL_W'({pack, data});
  assign byte_cnt_inc = byte_cnt + BCW'(1);
  assign height_ok    = (line_cnt == LCW'(FRAME_LINE));

  assign fire = pxl_info_vld_i & pxl_info_rdy_o & ~cfg_stop_i;
  assign room = ~pxl_vld_o | pxl_rdy_i;
  assign take = fire & byte_beat;
  assign load = take & last_byte & room;
  assign drop = take & last_byte & ~room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cfg_stop_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (cfg_start_i) state_nxt = WAIT_VS;
        WAIT_VS:    if (fire && vs) state_nxt = WAIT_SOF;
        WAIT_SOF:   if (take) state_nxt = ACTIVE;
        ACTIVE: begin
          if (fire) begin
            if (vs)            state_nxt = WAIT_SOF;
            else if (line_end) state_nxt = LINE_GAP;
            else if (len_err)  state_nxt = WAIT_VS;
          end
        end
        LINE_GAP: begin
          if (fire) begin
            if (frame_end)      state_nxt = cfg_single_i ? DONE : WAIT_SOF;
            else if (byte_beat) state_nxt = ACTIVE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Beat classification for the current state; the input is only held back
  // when a completed pixel has nowhere to go and stalling is selected.
  always_comb begin
    byte_beat = 1'b0;
    line_end  = 1'b0;
    len_err   = 1'b0;
    frame_end = 1'b0;
    case (state)
      WAIT_SOF: byte_beat = hs & ~vs;
      ACTIVE: begin
        if (vs) begin
          len_err = 1'b1;
        end else if (!hs) begin
          if (byte_cnt == BCW'(LINE_BYTES)) line_end = 1'b1;
          else                              len_err  = 1'b1;
        end else if (byte_cnt == BCW'(LINE_BYTES)) begin
          len_err = 1'b1;
        end else begin
          byte_beat = 1'b1;
        end
      end
      LINE_GAP: begin
        if (vs)      frame_end = 1'b1;
        else if (hs) byte_beat = 1'b1;
      end
      default: ;
    endcase
    last_byte      = byte_beat & (sub_cnt == SCW'(PXL_BYTES - 1));
    pxl_info_rdy_o = ~(last_byte & pxl_vld_o & ~pxl_rdy_i & cfg_stall_i & ~cfg_stop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      sub_cnt  <= '0;
      pack     <= '0;
    end else if (cfg_stop_i) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      sub_cnt  <= '0;
      pack     <= '0;
    end else if (fire) begin
      if (take) begin
        byte_cnt <= byte_cnt_inc;
        sub_cnt  <= last_byte ? '0 : sub_cnt + SCW'(1);
        pack     <= pack_nxt;
      end
      if (line_end) begin
        byte_cnt <= '0;
        if (line_cnt != '1) line_cnt <= line_cnt + LCW'(1);
      end
      if (len_err) begin
        byte_cnt <= '0;
        line_cnt <= '0;
        sub_cnt  <= '0;
        pack     <= '0;
      end
      if (frame_end) line_cnt <= '0;
    end
  end

  // Output register: loads in the same cycle the previous pixel is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl_o     <= '0;
      pxl_vld_o <= 1'b0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
    end else if (load) begin
      pxl_o     <= pack_nxt;
      pxl_vld_o <= 1'b1;
      sof_o     <= (line_cnt == '0) && (byte_cnt_inc == BCW'(PXL_BYTES));
      eol_o     <= (byte_cnt_inc == BCW'(LINE_BYTES));
    end else if (pxl_rdy_i) begin
      pxl_vld_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_o <= 1'b0;
      err_code_o   <= 3'b000;
    end else begin
      frame_done_o <= fire & frame_end & height_ok;
      err_code_o   <= (err_clr_i ? 3'b000 : err_code_o) |
                      {drop, fire & frame_end & ~height_ok, fire & len_err};
    end
  end

  assign err_o = |err_code_o;

endmodule

// File: tb/tb_dvp_frame_gate.sv
// tb/tb_dvp_frame_gate.sv - scoreboard bench for dvp_frame_gate against a line-level reference model
module tb_dvp_frame_gate;
  localparam int DW = 8;
  localparam int PB = 2;
  localparam int PW = DW * PB;
  localparam int LP = 4;
  localparam int FL = 2;
  localparam int LB = LP * PB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW+1:0] pxl_info_i = '0;
  logic          pxl_info_vld_i = 1'b0;
  logic          pxl_info_rdy_o;
  logic          cfg_start_i = 1'b0, cfg_stop_i = 1'b0, cfg_single_i = 1'b0;
  logic          cfg_stall_i = 1'b1, err_clr_i = 1'b0;
  logic [PW-1:0] pxl_o;
  logic          pxl_vld_o, pxl_rdy_i, sof_o, eol_o, frame_done_o, err_o;
  logic [2:0]    err_code_o;

  dvp_frame_gate #(.DVP_DATA_W(DW), .PXL_BYTES(PB), .PXL_W(PW), .LINE_PXL(LP), .FRAME_LINE(FL)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_info_i(pxl_info_i), .pxl_info_vld_i(pxl_info_vld_i),
    .pxl_info_rdy_o(pxl_info_rdy_o), .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
    .cfg_single_i(cfg_single_i), .cfg_stall_i(cfg_stall_i), .err_clr_i(err_clr_i),
    .pxl_o(pxl_o), .pxl_vld_o(pxl_vld_o), .pxl_rdy_i(pxl_rdy_i), .sof_o(sof_o), .eol_o(eol_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [DW+1:0] beats[$];
  logic [PW+1:0] exp_q[$];
  int exp_done;
  logic [2:0] exp_err;
  int fn[4];
  int fl[4][4];
  int nframes;
  bit fixed_gaps = 1'b1;
  int gap_pct = 0;
  int rdy_mode = 0;
  int hold_at = -1;
  int hold_trig = 0;
  bit sub_mode = 1'b0;
  int n_done = 0, n_pix = 0, n_drop = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer ready: always, random, or held low; a 5-cycle low window on request.
  initial begin : rdy_gen
    int seen, hcnt;
    seen = 0;
    hcnt = 0;
    pxl_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_trig != seen) begin
        seen = hold_trig;
        hcnt = 5;
      end
      if (hcnt > 0) begin
        pxl_rdy_i = 1'b0;
        hcnt--;
      end else begin
        case (rdy_mode)
          0:       pxl_rdy_i = 1'b1;
          1:       pxl_rdy_i = ($urandom_range(99) < 65);
          default: pxl_rdy_i = 1'b0;
        endcase
      end
    end
  end

  initial begin : monitor
    logic [PW+1:0] got;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_done_o) n_done++;
        if (pxl_vld_o && pxl_rdy_i) begin
          got = {pxl_o, sof_o, eol_o};
          n_pix++;
          if (sub_mode) begin
            while (exp_q.size() > 0 && exp_q[0] != got) begin
              void'(exp_q.pop_front());
              n_drop++;
            end
          end
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pixel_unexpected: got %0h with nothing expected", got);
          end else begin
            check("pixel", got, exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic int nrep(input int hi);
    return fixed_gaps ? 1 : int'($urandom_range(hi, 1));
  endfunction

  // Reference model works per frame and per line: every frame is captured
  // unless single mode already finished; a bad line aborts the rest of its frame.
  task automatic build_stream(input bit single, input bit ramp);
    bit ended;
    ended = 1'b0;
    beats.delete();
    exp_q.delete();
    exp_done = 0;
    exp_err = 3'b000;
    for (int f = 0; f < nframes; f++) begin
      bit bad;
      int good;
      bad = 1'b0;
      good = 0;
      repeat (nrep(2)) beats.push_back({1'b1, 1'b0, 8'h00});
      repeat (nrep(2)) beats.push_back({1'b0, 1'b0, 8'h00});
      for (int l = 0; l < fn[f]; l++) begin
        logic [7:0] b[$];
        int usable;
        b.delete();
        for (int k = 0; k < fl[f][l]; k++) begin
          b.push_back(ramp ? 8'(8'h10 + k) : 8'($urandom));
          beats.push_back({1'b0, 1'b1, b[k]});
        end
        if (!ended && !bad) begin
          usable = (fl[f][l] < LB) ? fl[f][l] : LB;
          for (int p = 0; (p + 1) * PB <= usable; p++) begin
            logic [PW-1:0] px;
            px = '0;
            for (int j = 0; j < PB; j++) px = (px << 8) | PW'(b[p * PB + j]);
            exp_q.push_back({px, (good == 0 && p == 0), ((p + 1) * PB == LB)});
          end
          if (fl[f][l] != LB) begin
            bad = 1'b1;
            exp_err[0] = 1'b1;
          end else begin
            good++;
          end
        end
        repeat (nrep(3)) beats.push_back({1'b0, 1'b0, 8'h00});
      end
      if (!ended && !bad) begin
        if (good == FL) exp_done++;
        else exp_err[1] = 1'b1;
        if (single) ended = 1'b1;
      end
    end
    beats.push_back({1'b1, 1'b0, 8'h00});
    beats.push_back({1'b0, 1'b0, 8'h00});
  endtask

  task automatic drive_stream();
    for (int i = 0; i < beats.size(); i++) begin
      bit acc;
      int guard;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        pxl_info_vld_i = 1'b0;
        @(posedge clk);
        #1;
      end
      pxl_info_i = beats[i];
      pxl_info_vld_i = 1'b1;
      if (i == hold_at) hold_trig++;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = pxl_info_rdy_o;
        if (!acc) stall_cycles++;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", i, guard);
        break;
      end
    end
    pxl_info_vld_i = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_capture();
    cfg_stop_i = 1'b1;
    tick(1);
    cfg_stop_i = 1'b0;
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    cfg_start_i = 1'b1;
    tick(1);
    cfg_start_i = 1'b0;
  endtask

  task automatic set_frame(input int f, input int n, input int a, input int b, input int c);
    fn[f] = n;
    fl[f][0] = a;
    fl[f][1] = b;
    fl[f][2] = c;
  endtask

  task automatic run(input string name, input bit single, input bit stall, input bit ramp,
                     input bit smode, input bit exp_ovr, output int pix, output int drops);
    int d0, p0, r0;
    cfg_single_i = single;
    cfg_stall_i = stall;
    sub_mode = smode;
    build_stream(single, ramp);
    exp_err[2] = exp_ovr;
    stall_cycles = 0;
    start_capture();
    d0 = n_done;
    p0 = n_pix;
    r0 = n_drop;
    drive_stream();
    rdy_mode = 0;
    tick(12);
    pix = n_pix - p0;
    drops = n_drop - r0 + exp_q.size();
    if (!smode) check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_done"}, n_done - d0, exp_done);
    check({name, "_err_code"}, err_code_o, exp_err);
    check({name, "_err_o"}, err_o, |exp_err);
  endtask

  initial begin : main
    int pix, drops;
    #12;
    check("reset_outputs", {pxl_o, pxl_vld_o, sof_o, eol_o, frame_done_o, err_code_o, err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("idle_rdy", pxl_info_rdy_o, 1);

    // good frames, continuous
    nframes = 1;
    set_frame(0, 2, LB, LB, 0);
    run("good", 0, 1, 1, 0, 0, pix, drops);
    check("good_pix", pix, 8);
    nframes = 2;
    set_frame(1, 2, LB, LB, 0);
    run("cont2", 0, 1, 1, 0, 0, pix, drops);
    check("cont2_pix", pix, 16);

    // single-frame: second frame ignored
    run("single", 1, 1, 1, 0, 0, pix, drops);
    check("single_pix", pix, 8);

    // short line, recovery on next VSYNC, then clear
    set_frame(0, 2, 6, LB, 0);
    run("short", 0, 1, 1, 0, 0, pix, drops);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("err_clr", {err_o, err_code_o}, 0);

    // frame height
    nframes = 1;
    set_frame(0, 3, LB, LB, LB);
    run("height", 0, 1, 1, 0, 0, pix, drops);
    check("height_pix", pix, 12);

    // backpressure: stall, then drop
    set_frame(0, 2, LB, LB, 0);
    hold_at = 5;
    run("stall", 0, 1, 1, 0, 0, pix, drops);
    check("stall_pix", pix, 8);
    check("stall_seen", stall_cycles > 0, 1);
    run("drop", 0, 0, 1, 1, 1, pix, drops);
    check("drop_no_stall", stall_cycles, 0);
    check("drop_some", (pix < 8) && (drops > 0), 1);
    hold_at = -1;

    // randomized frames, stall mode, random consumer ready
    for (int it = 0; it < 8; it++) begin
      fixed_gaps = 1'b0;
      gap_pct = 20;
      nframes = $urandom_range(3, 1);
      for (int f = 0; f < nframes; f++) begin
        fn[f] = ($urandom_range(99) < 60) ? FL : int'($urandom_range(3, 1));
        for (int l = 0; l < 4; l++) fl[f][l] = ($urandom_range(99) < 70) ? LB : int'($urandom_range(10, 5));
      end
      rdy_mode = 1;
      run("rand", 1'($urandom_range(1)), 1, 0, 0, 0, pix, drops);
    end
    fixed_gaps = 1'b1;
    gap_pct = 0;

    // async reset mid-line with a pixel held in the output register
    cfg_stall_i = 1'b1;
    cfg_single_i = 1'b0;
    sub_mode = 1'b0;
    rdy_mode = 2;
    tick(1);
    start_capture();
    exp_q.delete();
    beats.delete();
    beats.push_back({1'b1, 1'b0, 8'h00});
    beats.push_back({1'b0, 1'b0, 8'h00});
    beats.push_back({1'b0, 1'b1, 8'h10});
    beats.push_back({1'b0, 1'b1, 8'h11});
    beats.push_back({1'b0, 1'b1, 8'h12});
    drive_stream();
    check("pre_reset_vld", {pxl_vld_o, pxl_o, sof_o}, {1'b1, 16'h1011, 1'b1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {pxl_o, pxl_vld_o, sof_o, eol_o, frame_done_o, err_code_o, err_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // stop mid-line: IDLE at once, held pixel still handshakes
    start_capture();
    beats.delete();
    beats.push_back({1'b1, 1'b0, 8'h00});
    beats.push_back({1'b0, 1'b0, 8'h00});
    beats.push_back({1'b0, 1'b1, 8'hA0});
    beats.push_back({1'b0, 1'b1, 8'hA1});
    beats.push_back({1'b0, 1'b1, 8'hA2});
    exp_q.push_back({16'hA0A1, 1'b1, 1'b0});
    drive_stream();
    cfg_stop_i = 1'b1;
    tick(1);
    cfg_stop_i = 1'b0;
    check("stop_holds", {pxl_vld_o, pxl_o}, {1'b1, 16'hA0A1});
    beats.delete();
    beats.push_back({1'b0, 1'b1, 8'hA3});
    beats.push_back({1'b0, 1'b1, 8'hA4});
    beats.push_back({1'b0, 1'b1, 8'hA5});
    stall_cycles = 0;
    drive_stream();
    check("stop_idle_discard", stall_cycles, 0);
    check("stop_err", err_code_o, 0);
    rdy_mode = 0;
    tick(4);
    check("stop_held_taken", exp_q.size(), 0);
    check("stop_vld_clear", pxl_vld_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
